// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter giving one of three byte-stream requesters the UART transmitter
// for a whole message, with an idle timeout on the owner and a forced inter-message gap.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_data,
  input  logic [2:0]  req_last,
  output logic [2:0]  req_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        timeout_pulse
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, GAP} state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] GAP_LAST      = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t      state_reg, state_next;
  logic [2:0]  grant_reg, grant_next;
  logic [1:0]  last_reg, last_next;
  logic        tx_valid_reg, tx_valid_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic [15:0] idle_cnt_reg, idle_cnt_next;
  logic [15:0] gap_cnt_reg, gap_cnt_next;
  logic        pulse_reg, pulse_next;

  logic        out_free, xfer, sel_valid, sel_last;
  logic [2:0]  xfer_vec;
  logic [7:0]  sel_data;
  logic [7:0]  masked_data [3];
  logic [1:0]  rr_first, rr_second, rr_third, rr_win, grant_idx;
  logic [15:0] idle_inc;

  // Byte of the current owner; grant is one-hot so an AND-OR mux suffices.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sel
      assign masked_data[gi] = grant_reg[gi] ? req_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

  assign sel_data  = masked_data[0] | masked_data[1] | masked_data[2];
  assign sel_valid = |(grant_reg & req_valid);
  assign sel_last  = |(grant_reg & req_last);
  assign out_free  = !tx_valid_reg || tx_ready;
  assign req_ready = (state_reg == STREAM && out_free) ? grant_reg : 3'b000;
  assign xfer_vec  = req_valid & req_ready;
  assign xfer      = |xfer_vec;
  assign idle_inc  = idle_cnt_reg + 16'd1;

  // Search order starts just after the previous owner.
  assign rr_first  = (last_reg  == 2'd2) ? 2'd0 : last_reg  + 2'd1;
  assign rr_second = (rr_first  == 2'd2) ? 2'd0 : rr_first  + 2'd1;
  assign rr_third  = (rr_second == 2'd2) ? 2'd0 : rr_second + 2'd1;

  always_comb begin
    rr_win = rr_third;
    if (req_valid[rr_first]) begin
      rr_win = rr_first;
    end else if (req_valid[rr_second]) begin
      rr_win = rr_second;
    end
  end

  assign grant_idx = grant_reg[2] ? 2'd2 : (grant_reg[1] ? 2'd1 : 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= 3'b000;
      last_reg     <= 2'd2;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      idle_cnt_reg <= 16'd0;
      gap_cnt_reg  <= 16'd0;
      pulse_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      last_reg     <= last_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
      idle_cnt_reg <= idle_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      pulse_reg    <= pulse_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    last_next     = last_reg;
    tx_valid_next = tx_valid_reg;
    tx_data_next  = tx_data_reg;
    idle_cnt_next = idle_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    pulse_next    = 1'b0;

    // A load and a drain can coincide; the load wins and keeps tx_valid high.
    if (xfer) begin
      tx_data_next  = sel_data;
      tx_valid_next = 1'b1;
    end else if (tx_valid_reg && tx_ready) begin
      tx_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          grant_next    = 3'b001 << rr_win;
          idle_cnt_next = 16'd0;
          state_next    = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          idle_cnt_next = 16'd0;
          if (sel_last) begin
            state_next = DRAIN;
          end
        end else if (!sel_valid) begin
          idle_cnt_next = idle_inc;
          if (idle_inc >= TIMEOUT_LIMIT) begin
            pulse_next = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!tx_valid_reg) begin
          grant_next   = 3'b000;
          last_next    = grant_idx;
          gap_cnt_next = 16'd0;
          state_next   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_reg >= GAP_LAST) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_valid      = tx_valid_reg;
  assign tx_data       = tx_data_reg;
  assign grant         = grant_reg;
  assign busy          = (state_reg != IDLE);
  assign timeout_pulse = pulse_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: a message-level model predicts the
// round-robin owner, the byte stream, gap lengths and timeouts; a monitor checks them.
module tb_uart_tx_arbiter;

  localparam int TO  = 8;
  localparam int GAP = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [23:0] req_data = 24'h0;
  logic [2:0]  req_last = 3'b000;
  logic [2:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic [2:0]  grant;
  logic        busy;
  logic        timeout_pulse;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // Stimulus: per requester a list of messages; truncated ones stop early with no last.
  logic [7:0] mb [3][8][8];
  int         msend [3][8];
  bit         mtrunc [3][8];
  int         nmsg [3];
  int         dly [3];
  int         idx [3];
  int         pos [3];
  int         lowrun [3];
  bit         waitrel [3];
  bit         rand_valid = 1'b0;
  bit         tx_rand = 1'b0;
  logic [2:0] hs_s, g_s;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q [$];
  int         exp_to = 0;
  int         seen_to = 0;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [2:0] v);
    for (int k = 1; k <= 3; k++) begin
      if (v[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic clear_msgs();
    for (int i = 0; i < 3; i++) begin
      nmsg[i] = 0; idx[i] = 0; pos[i] = 0; lowrun[i] = 0; waitrel[i] = 1'b0; dly[i] = 0;
    end
  endtask

  task automatic add_msg(input int r, input int len, input bit trunc);
    int m;
    m = nmsg[r];
    for (int b = 0; b < len; b++) mb[r][m][b] = 8'($urandom);
    msend[r][m]  = len;
    mtrunc[r][m] = trunc;
    nmsg[r]      = m + 1;
  endtask

  // One clock of every requester's driver: sample handshakes, then present next byte.
  task automatic step();
    logic [2:0]  v;
    logic [2:0]  l;
    logic [23:0] d;
    @(negedge clk);
    hs_s = req_valid & req_ready;
    g_s  = grant;
    @(posedge clk);
    #1;
    v = 3'b000; l = 3'b000; d = 24'h0;
    for (int i = 0; i < 3; i++) begin
      if (hs_s[i]) begin
        pos[i]++;
        if (pos[i] == msend[i][idx[i]]) begin
          if (mtrunc[i][idx[i]]) waitrel[i] = 1'b1;
          else begin idx[i]++; pos[i] = 0; end
        end
      end
      if (waitrel[i] && !g_s[i]) begin
        waitrel[i] = 1'b0; idx[i]++; pos[i] = 0;
      end
      if (dly[i] > 0) begin
        dly[i]--;
      end else if (idx[i] < nmsg[i] && !waitrel[i]) begin
        if (rand_valid && lowrun[i] < 3 && $urandom_range(0, 3) == 0) lowrun[i]++;
        else begin v[i] = 1'b1; lowrun[i] = 0; end
      end
      if (idx[i] < nmsg[i] && !waitrel[i]) begin
        d[8*i +: 8] = mb[i][idx[i]][pos[i]];
        l[i] = !mtrunc[i][idx[i]] && (pos[i] == msend[i][idx[i]] - 1);
      end
    end
    req_valid = v; req_data = d; req_last = l;
    if (tx_rand) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_phase(input string nm, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      step();
      done = (idx[0] >= nmsg[0]) && (idx[1] >= nmsg[1]) && (idx[2] >= nmsg[2]) &&
             !busy && (exp_q.size() == 0);
    end
    chk({"phase_complete_", nm}, int'(done), 1);
  endtask

  // Monitor / scoreboard.
  int         m_gap, m_toc, m_last, m_w;
  bit         m_gaptx, p_rst, p_busy, p_pulse;
  logic [2:0] p_rv, p_grant;
  logic [7:0] m_e;

  initial begin : monitor
    m_gap = 0; m_toc = 0; m_last = 2; m_gaptx = 0;
    p_rst = 0; p_busy = 0; p_pulse = 0; p_rv = 0; p_grant = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_last = 2; m_gap = 0; m_gaptx = 0; m_toc = 0;
        p_rst = 0; p_busy = 0; p_pulse = 0; p_grant = 0; p_rv = 0;
      end else begin
        if (p_rst && !p_busy) begin
          if (p_rv != 3'b000) begin
            m_w = rr_pick(m_last, p_rv);
            chk("arb_grant", int'(grant), 1 << m_w);
            if (idx[m_w] < nmsg[m_w]) begin
              for (int b = 0; b < msend[m_w][idx[m_w]]; b++) exp_q.push_back(mb[m_w][idx[m_w]][b]);
              if (mtrunc[m_w][idx[m_w]]) exp_to++;
            end
            m_last = m_w;
            m_toc  = 0;
          end else begin
            chk("idle_no_grant", int'(grant), 0);
          end
        end
        if (timeout_pulse) begin
          seen_to++;
          chk("timeout_idle_cycles", m_toc, TO);
          chk("timeout_one_cycle", int'(p_pulse), 0);
        end
        if (|(req_valid & req_ready)) m_toc = 0;
        else if (grant != 3'b000 && !(|(grant & req_valid))) m_toc++;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            chk("tx_unexpected_byte", int'(tx_data), -1);
          end else begin
            m_e = exp_q.pop_front();
            chk("tx_byte", int'(tx_data), int'(m_e));
          end
        end
        if (busy && grant == 3'b000) begin
          m_gap++;
          if (tx_valid) m_gaptx = 1'b1;
        end else if (m_gap > 0) begin
          chk("gap_cycles", m_gap, GAP);
          chk("gap_tx_quiet", int'(m_gaptx), 0);
          m_gap = 0; m_gaptx = 1'b0;
        end
        if (p_grant != 3'b000 && grant != 3'b000) chk("grant_hold", int'(grant), int'(p_grant));
        chk("req_ready_owner_only", int'(req_ready & ~grant), 0);
        if (tx_valid && !tx_ready) chk("req_ready_stalled", int'(req_ready), 0);
        p_rst = 1'b1; p_busy = busy; p_grant = grant; p_rv = req_valid; p_pulse = timeout_pulse;
      end
    end
  end

  initial begin : main
    int n;
    clear_msgs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(timeout_pulse), 0);
    chk("rst_req_ready", int'(req_ready), 0);

    // All three requesters with 2-byte messages from reset: order 0,1,2.
    for (int r = 0; r < 3; r++) add_msg(r, 2, 1'b0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_phase("three_way", 500);

    // Requester 1 sends "AB" into a stalled serializer.
    clear_msgs();
    add_msg(1, 2, 1'b0);
    mb[1][0][0] = 8'h41; mb[1][0][1] = 8'h42;
    tx_ready = 1'b0;
    n = 0;
    while (n < 50 && !tx_valid) begin step(); n++; end
    chk("stall_loaded", int'(tx_valid), 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_tx_valid", int'(tx_valid), 1);
      chk("stall_tx_data", int'(tx_data), 8'h41);
      chk("stall_req_ready1", int'(req_ready[1]), 0);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    run_phase("stall", 200);

    // One byte without last, then silence: must time out.
    clear_msgs();
    add_msg(0, 1, 1'b1);
    run_phase("timeout", 200);
    chk("timeout_count_single", seen_to, 1);

    // Requester 0 appears while requester 2 streams: no preemption.
    clear_msgs();
    add_msg(2, 6, 1'b0);
    add_msg(0, 2, 1'b0);
    dly[0] = 4;
    run_phase("no_preempt", 300);

    // Single requester, back-to-back messages.
    clear_msgs();
    for (int m = 0; m < 3; m++) add_msg(1, $urandom_range(1, 4), 1'b0);
    run_phase("repeat_req1", 400);

    // Randomized traffic with occasional truncated messages.
    clear_msgs();
    rand_valid = 1'b1; tx_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int m = 0; m < 5; m++) add_msg(r, $urandom_range(1, 5), ($urandom_range(0, 4) == 0));
      dly[r] = $urandom_range(0, 10);
    end
    run_phase("random", 4000);

    // Reset pulsed mid-message while a byte sits in the output register.
    clear_msgs();
    rand_valid = 1'b0; tx_rand = 1'b0; tx_ready = 1'b0;
    add_msg(2, 4, 1'b0);
    n = 0;
    while (n < 50 && !tx_valid) begin step(); n++; end
    chk("midrst_loaded", int'(tx_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", int'(tx_valid), 0);
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_tx_data", int'(tx_data), 0);
    req_valid = 3'b000; req_last = 3'b000; req_data = 24'h0;
    clear_msgs();
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) add_msg(r, 3, 1'b0);
    tx_rand = 1'b1;
    rst_n = 1'b1;
    run_phase("after_reset", 600);

    chk("timeout_count_total", seen_to, exp_to);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
